hazard_ctrl: RTL

//  Pipeline hazard controller. Generates the 2-bit HzCtrl commands consumed by the PC, IF/ID and ID/EX registers.

---
 rtl/hz_pkg.sv | 32 +++
 rtl/hz_md_timer.sv | 42 ++++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hz_pkg.sv
// Shared hazard-control definitions: HzCtrl command codes, FSM states, command bundle.
// The HzCtrl codes are also consumed by the PC, IF/ID and ID/EX pipeline registers.
// Code 2'b11 is reserved and never produced.
package hz_pkg;

  localparam logic [1:0] HZ_NORMAL = 2'b00;
  localparam logic [1:0] HZ_FLUSH  = 2'b01;
  localparam logic [1:0] HZ_STALL  = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

  // One HzCtrl command per controlled pipeline register.
  typedef struct packed {
    logic [1:0] pc;
    logic [1:0] if_id;
    logic [1:0] id_ex;
  } hz_cmd_t;

  function automatic hz_cmd_t hz_cmd(input logic [1:0] pc,
                                     input logic [1:0] if_id,
                                     input logic [1:0] id_ex);
    hz_cmd_t c;
    c.pc    = pc;
    c.if_id = if_id;
    c.id_ex = id_ex;
    return c;
  endfunction

endpackage

// File: rtl/hz_md_timer.sv
// MULT/DIV occupancy down-counter: load, decrement-while-nonzero, clear; zero flag.
// Latency: count updates one cycle after load/dec/clr; zero_o is combinational from the count.
// No backpressure; clear beats load, load beats decrement, decrement never wraps.
module hz_md_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, decrement is blocked at zero so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, ID jump flush, multi-cycle MULT/DIV stall.
// Latency: HzCtrl outputs are Mealy (same cycle as inputs); md_busy and counters are registered.
// No handshake; stall is expressed through the HzCtrl codes. Optional HZ_PERF_CNT_EN adds stall/flush counters.
module hazard_ctrl
  import hz_pkg::*;
#(
  parameter int MD_LAT = 8   // MULT/DIV occupancy in ID, in cycles; must be >= 2
`ifdef HZ_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic       id_md_start,
  input  logic       ex_memrd,
  input  logic [4:0] ex_rt_addr,
  input  logic       ex_redirect,
  output logic [1:0] pc_hz,
  output logic [1:0] if_id_hz,
  output logic [1:0] id_ex_hz,
  output logic       md_busy
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int MD_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  // The first stalled cycle is spent in RUN, so MD_WAIT counts the remaining MD_LAT-2 stalls.
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT - 2);

  hz_state_e state_q;
  hz_state_e state_d;
  hz_cmd_t   cmd;
  logic      load_use;
  logic      md_clr;
  logic      md_load;
  logic      md_dec;
  logic      md_zero;

  // A load in EX whose destination is a live source of the ID instruction; $zero never creates a hazard.
  assign load_use = ex_memrd && (ex_rt_addr != 5'd0) &&
                    ((ex_rt_addr == id_rs_addr) ||
                     (id_uses_rt && (ex_rt_addr == id_rt_addr)));

  // Priority-ordered command selection and FSM next-state.
  always_comb begin
    cmd     = hz_cmd(HZ_NORMAL, HZ_NORMAL, HZ_NORMAL);
    state_d = state_q;
    md_clr  = 1'b0;
    md_load = 1'b0;
    md_dec  = 1'b0;
    if (ex_redirect) begin
      // Redirect kills everything younger, including an MD op sitting in ID.
      cmd     = hz_cmd(HZ_NORMAL, HZ_FLUSH, HZ_FLUSH);
      state_d = RUN;
      md_clr  = 1'b1;
    end else if (state_q == MD_WAIT) begin
      if (!md_zero) begin
        cmd    = hz_cmd(HZ_STALL, HZ_STALL, HZ_FLUSH);
        md_dec = 1'b1;
      end else begin
        // Advancing cycle: the MD op moves to EX; a new id_md_start is not looked at here.
        state_d = RUN;
      end
    end else if (load_use) begin
      // Single-cycle stall: EX holds a bubble next cycle, so the compare clears by itself.
      cmd = hz_cmd(HZ_STALL, HZ_STALL, HZ_FLUSH);
    end else if (id_md_start) begin
      cmd     = hz_cmd(HZ_STALL, HZ_STALL, HZ_FLUSH);
      state_d = MD_WAIT;
      md_load = 1'b1;
    end else if (id_jump) begin
      cmd = hz_cmd(HZ_NORMAL, HZ_FLUSH, HZ_NORMAL);
    end
  end

  // FSM state register; reset returns to RUN immediately, aborting any MD sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  hz_md_timer #(
    .W (MD_W)
  ) u_md_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (md_clr),
    .load_i     (md_load),
    .load_val_i (MD_LOAD),
    .dec_i      (md_dec),
    .zero_o     (md_zero)
  );

  // Outputs are forced to NORMAL while reset is held so no stale command leaks out.
  assign pc_hz    = rst ? HZ_NORMAL : cmd.pc;
  assign if_id_hz = rst ? HZ_NORMAL : cmd.if_id;
  assign id_ex_hz = rst ? HZ_NORMAL : cmd.id_ex;
  assign md_busy  = (state_q == MD_WAIT);

  // Jump and MD start together is a decoder bug; MD wins in the priority chain above.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(id_jump && id_md_start));
    end
  end

`ifdef HZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters for PC stalls and IF/ID flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((pc_hz == HZ_STALL) && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((if_id_hz == HZ_FLUSH) && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
